// File: rtl/sm_hex_scan_ctrl_if.sv
// sm_hex_scan_ctrl_if: frame-offer handshake carrying number, dots, mask and brightness.
interface sm_hex_scan_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_number;
  logic [7:0]  in_dots;
  logic [7:0]  in_mask;
  logic [2:0]  in_bright;
  modport master (output in_valid, in_number, in_dots, in_mask, in_bright, input in_ready);
  modport slave  (input in_valid, in_number, in_dots, in_mask, in_bright, output in_ready);
endinterface

// File: rtl/sm_hex_scan_ctrl.sv
// sm_hex_scan_ctrl: 8-digit multiplexed 7-segment scanner with tear-free double-buffered frames.
// Define SM_HEX_SCAN_CTRL_LZB_EN to enable leading-zero blanking.
module sm_hex_scan_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                resetn,
  sm_hex_scan_ctrl_if.slave   in_if,
  output logic [6:0]          seven_segments,
  output logic                dot,
  output logic [7:0]          anodes,
  output logic                frame_start
);
  typedef struct packed {
    logic [31:0] num;
    logic [7:0]  dots;
    logic [7:0]  mask;
    logic [2:0]  bright;
  } frame_t;
  localparam frame_t FRAME_RST = '{num: 32'h0, dots: 8'h0, mask: 8'hFF, bright: 3'h7};
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  frame_t           shadow_q, shadow_d, active_q, active_d;
  logic             bound_q;
  logic [6:0]       seg_q, seg_d;
  logic             dot_q, dot_d;
  logic [7:0]       an_q, an_d;
  logic             fs_q;
  logic             tick, boundary, accept, lit;
  logic [3:0]       nib;
  logic [7:0]       blank;
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0011000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction
  assign tick           = &cnt_q;
  assign boundary       = tick && (idx_q == 3'd7);
  assign accept         = in_if.in_valid && !pending_q;
  assign in_if.in_ready = !pending_q;
`ifdef SM_HEX_SCAN_CTRL_LZB_EN
  logic lz_run;
  // blank[k] is set while every nibble and dot from digit 7 down to k is zero
  always_comb begin
    blank  = 8'h00;
    lz_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      lz_run   = lz_run && (active_q.num[4*k +: 4] == 4'h0) && !active_q.dots[k];
      blank[k] = lz_run;
    end
  end
`else
  assign blank = 8'h00;
`endif
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    shadow_d  = accept ? '{num: in_if.in_number, dots: in_if.in_dots, mask: in_if.in_mask, bright: in_if.in_bright} : shadow_q;
    pending_d = accept || (pending_q && !boundary);
    active_d  = (boundary && pending_q) ? shadow_q : active_q;
    nib       = active_q.num[{idx_q, 2'b00} +: 4];
    lit       = active_q.mask[idx_q] && !blank[idx_q] && (cnt_q[CNT_W-1 -: 3] <= active_q.bright);
    seg_d     = lit ? enc(nib) : 7'h7F;
    dot_d     = lit ? !active_q.dots[idx_q] : 1'b1;
    an_d      = lit ? ~(8'h01 << idx_q) : 8'hFF;
  end
  // frame_start is delayed twice so it lines up with the first registered digit-0 output
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      pending_q <= 1'b0;
      shadow_q  <= FRAME_RST;
      active_q  <= FRAME_RST;
      bound_q   <= 1'b0;
      seg_q     <= 7'h7F;
      dot_q     <= 1'b1;
      an_q      <= 8'hFF;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      bound_q   <= boundary;
      seg_q     <= seg_d;
      dot_q     <= dot_d;
      an_q      <= an_d;
      fs_q      <= bound_q;
    end
  end
  assign seven_segments = seg_q;
  assign dot            = dot_q;
  assign anodes         = an_q;
  assign frame_start    = fs_q;
endmodule

// File: tb/tb_sm_hex_scan_ctrl.sv
// tb_sm_hex_scan_ctrl: directed checks of scanning, frame handoff, brightness, blanking and reset.
module tb_sm_hex_scan_ctrl;
`ifdef SM_HEX_SCAN_CTRL_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [55:0] ZERO = {8{7'h40}};
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] seven_segments;
  logic       dot;
  logic [7:0] anodes;
  logic       frame_start;
  int         n_chk = 0;
  int         n_bad = 0;
  sm_hex_scan_ctrl_if bus ();
  sm_hex_scan_ctrl #(.CNT_W(3)) dut (
    .clock(clock), .resetn(resetn), .in_if(bus.slave),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes), .frame_start(frame_start)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 200);
  endtask
  task automatic offer(input string tag, input logic [31:0] num, input logic [7:0] dots, input logic [7:0] mask, input logic [2:0] bright);
    bus.in_number = num;
    bus.in_dots   = dots;
    bus.in_mask   = mask;
    bus.in_bright = bright;
    bus.in_valid  = 1'b1;
    check({tag, "_rdy"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
  endtask
  // starts at a frame_start sample, walks one frame, ends on the next frame_start sample
  task automatic scan(input string tag, input logic [55:0] segs, input logic [7:0] lit, input logic [7:0] dots, input int on_clks);
    logic [7:0] an_e;
    logic [6:0] sg_e;
    logic       dt_e;
    int         on;
    int         multi;
    multi = 0;
    for (int k = 0; k < 8; k++) begin
      an_e = lit[k] ? ~(8'h01 << k) : 8'hFF;
      sg_e = lit[k] ? segs[7*k +: 7] : 7'h7F;
      dt_e = lit[k] ? ~dots[k] : 1'b1;
      on = 0;
      for (int j = 0; j < 8; j++) begin
        if (j == 0) begin
          check($sformatf("%s_d%0d_an", tag, k), anodes, an_e);
          check($sformatf("%s_d%0d_seg", tag, k), seven_segments, sg_e);
          check($sformatf("%s_d%0d_dot", tag, k), dot, dt_e);
        end
        if (anodes != 8'hFF) on++;
        if ($countones(~anodes) > 1) multi++;
        step();
      end
      check($sformatf("%s_d%0d_on", tag, k), on, lit[k] ? on_clks : 0);
    end
    check({tag, "_multi_an"}, multi, 0);
    check({tag, "_next_fs"}, frame_start, 1);
  endtask
  // runs to the next frame_start, counting torn samples and samples with in_ready high
  task automatic run_to_fs(input logic [6:0] old_seg, output int tear, output int rdy_hi);
    int n;
    n = 0;
    tear = 0;
    rdy_hi = 0;
    while (!frame_start && n < 100) begin
      if (anodes != 8'hFF && seven_segments != old_seg) tear++;
      if (bus.in_ready) rdy_hi++;
      step();
      n++;
    end
  endtask
  initial begin
    int n;
    int tear;
    int rdy_hi;
    bus.in_valid  = 1'b0;
    bus.in_number = 32'h0;
    bus.in_dots   = 8'h0;
    bus.in_mask   = 8'h0;
    bus.in_bright = 3'h0;
    repeat (3) step();
    check("rst_seg", seven_segments, 7'h7F);
    check("rst_dot", dot, 1);
    check("rst_an", anodes, 8'hFF);
    check("rst_fs", frame_start, 0);
    check("rst_rdy", bus.in_ready, 1);
    resetn = 1'b1;
    wait_fs(n);
    check("first_fs", n, 65);
    scan("idle", ZERO, LZB ? 8'h01 : 8'hFF, 8'h00, 8);
    // new frame mid-frame: must wait for the boundary
    repeat (20) step();
    offer("hex", 32'h89ABCDEF, 8'h00, 8'hFF, 3'd7);
    check("hex_rdy_low", bus.in_ready, 0);
    run_to_fs(7'h40, tear, rdy_hi);
    check("hex_no_tear", tear, 0);
    check("hex_rdy_hi", rdy_hi, 1);
    check("hex_fs", frame_start, 1);
    check("hex_rdy_fs", bus.in_ready, 1);
    scan("hex", {7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF, 8'h00, 8);
    // second offer held while pending, taken the clock after the boundary
    repeat (10) step();
    offer("x1", 32'h01234567, 8'h00, 8'hFF, 3'd7);
    bus.in_number = 32'h76543210;
    bus.in_valid  = 1'b1;
    check("x2_blocked", bus.in_ready, 0);
    run_to_fs(7'h0E, tear, rdy_hi);
    check("x2_rdy_hi", rdy_hi, 1);
    check("x2_taken", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    scan("x1", {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, LZB ? 8'h7F : 8'hFF, 8'h00, 8);
    scan("x2", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF, 8'h00, 8);
    check("x2_rdy_after", bus.in_ready, 1);
    // minimum brightness with the upper four digits masked off
    repeat (5) step();
    offer("dim", 32'h0000ABCD, 8'h05, 8'h0F, 3'd0);
    wait_fs(n);
    scan("dim", {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21}, 8'h0F, 8'h05, 1);
    // leading zeros
    repeat (5) step();
    offer("lz", 32'h00000120, 8'h00, 8'hFF, 3'd7);
    wait_fs(n);
    scan("lz", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40}, LZB ? 8'h07 : 8'hFF, 8'h00, 8);
    // reset with a pending frame must discard it
    repeat (5) step();
    offer("pend", 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'd7);
    check("pend_rdy_low", bus.in_ready, 0);
    repeat (3) step();
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_seg", seven_segments, 7'h7F);
    check("mid_rst_dot", dot, 1);
    check("mid_rst_an", anodes, 8'hFF);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_rdy", bus.in_ready, 1);
    repeat (2) step();
    resetn = 1'b1;
    wait_fs(n);
    check("post_rst_fs", n, 65);
    scan("post_rst", ZERO, LZB ? 8'h01 : 8'hFF, 8'h00, 8);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
